cla_addsub28_pipe: RTL and testbench
====================================

Name: cla_addsub28_pipe

Overview:
Two-stage pipelined 28-bit carry-lookahead adder/subtractor with a valid/ready elastic interface on both sides.
- Subtraction is the primary mode: A + ~B + 1. This is the inverse companion to the team's combinational 28-bit adder.
- Sits in the mantissa datapath (align/normalise) between the exponent-compare stage and the normaliser.
- Produces result, carry/borrow, zero flag and sign-of-difference for downstream normalisation.

Parameters:
- WIDTH, 28, operand/result width; must be a multiple of GRP.
- GRP, 4, lookahead group size (WIDTH/GRP = 7 groups).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- in_sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  (A±B) mod 2^WIDTH.
- out_cout  output  1  add: carry-out; sub: 1 when A>=B (no borrow).
- out_neg  output  1  sub only: 1 when A<B; 0 in add mode.
- out_zero  output  1  out_sum == 0.

Behaviour:
- One clock (clk); reset asynchronous and active-high (rst). On rst:
  - both stage valid flags clear, so out_valid=0;
  - out_sum=0, out_cout=0, out_neg=0, out_zero=0;
  - in_ready=1 on the first edge after release.
- Stage 1 (capture) registers, on in_valid & in_ready:
  - A;
  - Bx = B ^ {WIDTH{in_sub}};
  - cin = in_sub;
  - per-bit P = A^Bx and G = A&Bx;
  - per-group GP/GG, computed by the sub-module;
  - the sub flag.
- Stage 2 (resolve):
  - group carry chain C[g+1] = GG[g] | GP[g]&C[g], with C[0] = cin;
  - intra-group ripple from the group carry-in;
  - S = P ^ C; cout = final carry;
  - neg = sub & ~cout; zero = ~|S.
  - Registered into the output register.
- Latency: exactly 2 cycles from the input handshake to out_valid with no backpressure. Throughput is 1 per cycle.
- Handshake:
  - s2_adv = out_valid & out_ready | ~out_valid.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = ~s1_valid | s2_adv.
  - in_ready must not depend combinationally on in_valid.
- Backpressure: with out_ready=0 and both stages full, in_ready=0. All registered data holds unchanged; no loss and no duplication.
- Simultaneous consume and accept in the same cycle: both stages shift, ordering is preserved, and no bubble is inserted.
- out_* data is stable while out_valid=1 and out_ready=0.
- Wrap-around: the sum is modulo 2^WIDTH.
  - add 0xFFFFFFF + 1 → sum 0, cout=1, zero=1.
  - sub 0 - 1 → sum 0xFFFFFFF, cout=0, neg=1.
- Sub with A==B: sum 0, cout=1, neg=0, zero=1.
- Reset mid-operation: all in-flight results are discarded and out_valid drops to 0 asynchronously.
- Data registers need no reset except the output register, which resets to 0 as listed above.

Decomposition:
- Package cla_pkg:
  - localparams CLA_WIDTH=28, CLA_GRP=4, CLA_NGRP=7;
  - typedef of the stage-1 struct {a, p, g, gp, gg, cin, sub}.
- Sub-module cla_grp_pg: generic GRP-bit group producing per-bit P/G plus group propagate/generate. Instantiated WIDTH/GRP times in stage 1.

Test Plan:
- Reset then add 0x0000003 + 0x0000005, out_ready=1 → after 2 cycles: out_sum=0x0000008, cout=0, zero=0, neg=0.
- Sub 0x0000005 - 0x0000009 → out_sum=0xFFFFFFC, cout=0, neg=1. Sub 0x1234567 - 0x1234567 → sum=0, cout=1, zero=1.
- Add 0xFFFFFFF + 0x0000001 → sum=0, cout=1, zero=1. Add 0x8000000 + 0x8000000 → sum=0, cout=1.
- Stream 10 back-to-back random ops with out_ready=1 → 10 results on consecutive cycles, in order, matching the reference model.
- Random out_ready toggling (50%) over 1000 ops → in-order, no drop or duplicate, and out_* stable while stalled. With both stages full and out_ready=0, in_ready=0.
- Assert rst with 2 ops in flight → out_valid=0 immediately. After release those ops never appear and the next op completes with latency 2.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and the stage-1 pipeline record for the 28-bit
// carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int CLA_WIDTH = 28;
    localparam int CLA_GRP   = 4;
    localparam int CLA_NGRP  = CLA_WIDTH / CLA_GRP;

    typedef struct packed {
        logic [CLA_WIDTH-1:0] a;
        logic [CLA_WIDTH-1:0] p;
        logic [CLA_WIDTH-1:0] g;
        logic [CLA_NGRP-1:0]  gp;
        logic [CLA_NGRP-1:0]  gg;
        logic                 cin;
        logic                 sub;
    } s1_t;

endpackage

// File: rtl/cla_grp_pg.sv
// One lookahead group: per-bit propagate/generate plus the group-level
// propagate and generate terms.
module cla_grp_pg #(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] a,
    input  logic [GRP-1:0] b,
    output logic [GRP-1:0] p,
    output logic [GRP-1:0] g,
    output logic           gp,
    output logic           gg
);

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = &p;
        gg = 1'b0;
        for (int i = 0; i < GRP; i++) begin
            gg = g[i] | (p[i] & gg);
        end
    end

endmodule

// File: rtl/cla_addsub28_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on
// both sides: stage 1 captures P/G and group terms, stage 2 resolves carries.
module cla_addsub28_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GRP   = CLA_GRP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_neg,
    output logic             out_zero
);

    localparam int NGRP = WIDTH / GRP;

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p_n;
    logic [WIDTH-1:0] g_n;
    logic [NGRP-1:0]  gp_n;
    logic [NGRP-1:0]  gg_n;

    s1_t  s1_q;
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    logic [NGRP:0]    gc;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;
    logic             carry;
    logic             unused_a;

    assign bx = in_b ^ {WIDTH{in_sub}};

    for (genvar k = 0; k < NGRP; k++) begin : g_pg
        cla_grp_pg #(.GRP(GRP)) u_pg (
            .a  (in_a[k*GRP +: GRP]),
            .b  (bx[k*GRP +: GRP]),
            .p  (p_n[k*GRP +: GRP]),
            .g  (g_n[k*GRP +: GRP]),
            .gp (gp_n[k]),
            .gg (gg_n[k])
        );
    end

    // in_ready looks only at pipeline state, never at in_valid.
    assign s2_adv   = (out_valid & out_ready) | ~out_valid;
    assign s1_adv   = s1_valid & s2_adv;
    assign in_ready = ~s1_valid | s2_adv;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_q <= '{a: in_a, p: p_n, g: g_n, gp: gp_n, gg: gg_n,
                      cin: in_sub, sub: in_sub};
        end
    end

    always_comb begin
        gc     = '0;
        sum_n  = '0;
        carry  = 1'b0;
        gc[0]  = s1_q.cin;
        for (int k = 0; k < NGRP; k++) begin
            gc[k+1] = s1_q.gg[k] | (s1_q.gp[k] & gc[k]);
        end
        // Ripple inside each group, restarting from the lookahead carry-in.
        for (int i = 0; i < WIDTH; i++) begin
            if (i % GRP == 0) begin
                carry = gc[i/GRP];
            end
            sum_n[i] = s1_q.p[i] ^ carry;
            carry    = s1_q.g[i] | (s1_q.p[i] & carry);
        end
        cout_n = gc[NGRP];
    end

    // Operand A rides along in stage 1 but the sum is fully resolved from P/G.
    assign unused_a = ^s1_q.a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_neg   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_sum  <= sum_n;
                out_cout <= cout_n;
                out_neg  <= s1_q.sub & ~cout_n;
                out_zero <= ~|sum_n;
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub28_pipe.sv
// Directed and streaming checks for the pipelined 28-bit adder/subtractor.
module tb_cla_addsub28_pipe;

    localparam int W = 28;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_neg;
    logic         out_zero;
    logic [31:0]  obs;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    bit          sb_on   = 1'b0;
    bit          acc     = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held    = '0;
    int          cyc     = 0;
    int          pops    = 0;
    int          first_pop = -1;
    int          last_pop  = 0;
    int          sent;
    int          guard;

    always #5 clk = ~clk;

    cla_addsub28_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_neg   (out_neg),
        .out_zero  (out_zero)
    );

    assign obs = {1'b0, out_zero, out_neg, out_cout, out_sum};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [W-1:0] s, input logic c, input logic n, input logic z);
        return {1'b0, z, n, c, s};
    endfunction

    function automatic logic [31:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W:0] t;
        logic       c;
        if (sub) begin
            t = {1'b0, a} - {1'b0, b};
            c = (a >= b);
        end else begin
            t = {1'b0, a} + {1'b0, b};
            c = t[W];
        end
        return pk(t[W-1:0], c, sub & ~c, t[W-1:0] == '0);
    endfunction

    always @(negedge clk) begin
        cyc++;
        acc = in_valid && in_ready;
        if (sb_on && !rst) begin
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", obs, held);
            end
            if (acc) exp_q.push_back(ref_res(in_a, in_b, in_sub));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
                else check("stream_data", obs, exp_q.pop_front());
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            stalled = out_valid && !out_ready;
            held    = obs;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic [31:0] exp);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, obs, exp);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", obs, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle_valid", 32'(out_valid), 32'd0);

        run_one("add_3_5",      28'h0000003, 28'h0000005, 1'b0, pk(28'h0000008, 1'b0, 1'b0, 1'b0));
        run_one("sub_5_9",      28'h0000005, 28'h0000009, 1'b1, pk(28'hFFFFFFC, 1'b0, 1'b1, 1'b0));
        run_one("sub_eq",       28'h1234567, 28'h1234567, 1'b1, pk(28'h0000000, 1'b1, 1'b0, 1'b1));
        run_one("add_wrap",     28'hFFFFFFF, 28'h0000001, 1'b0, pk(28'h0000000, 1'b1, 1'b0, 1'b1));
        run_one("add_msb",      28'h8000000, 28'h8000000, 1'b0, pk(28'h0000000, 1'b1, 1'b0, 1'b1));
        run_one("sub_0_1",      28'h0000000, 28'h0000001, 1'b1, pk(28'hFFFFFFF, 1'b0, 1'b1, 1'b0));
        run_one("sub_9_5",      28'h0000009, 28'h0000005, 1'b1, pk(28'h0000004, 1'b1, 1'b0, 1'b0));
        run_one("add_alt",      28'h5555555, 28'hAAAAAAA, 1'b0, pk(28'hFFFFFFF, 1'b0, 1'b0, 1'b0));
        run_one("sub_max_0",    28'hFFFFFFF, 28'h0000000, 1'b1, pk(28'hFFFFFFF, 1'b1, 1'b0, 1'b0));
        run_one("add_grp_ripl", 28'h0FFFFFF, 28'h0000001, 1'b0, pk(28'h1000000, 1'b0, 1'b0, 1'b0));
        repeat (2) begin @(posedge clk); #1; end

        // Back-to-back stream with the consumer always ready.
        sb_on = 1'b1; pops = 0; first_pop = -1;
        for (int i = 0; i < 10; i++) begin
            in_a = W'($urandom()); in_b = W'($urandom()); in_sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && pops < 10; i++) begin @(posedge clk); #1; end
        check("stream_count", 32'(pops), 32'd10);
        check("stream_back2back", 32'(last_pop - first_pop), 32'd9);
        drain("stream_drain");

        // Fill both stages against a stalled consumer.
        out_ready = 1'b0;
        in_a = 28'h0000010; in_b = 28'h0000001; in_sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 28'h0000020; in_b = 28'h0000022; in_sub = 1'b1;
        @(posedge clk); #1;
        in_a = 28'h0000007; in_b = 28'h0000008; in_sub = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("full_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("full_drain");

        // Random consumer backpressure over 1000 operations.
        pops = 0; sent = 0; guard = 0;
        while (sent < 1000 && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
            if (in_valid && acc) sent++;
            if (!in_valid || acc) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    in_a = W'($urandom()); in_b = W'($urandom()); in_sub = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        check("rand_sent", 32'(sent), 32'd1000);
        drain("rand_drain");
        check("rand_count", 32'(pops), 32'd1000);

        // Reset with two operations in flight.
        sb_on = 1'b0;
        out_ready = 1'b0;
        in_a = 28'h0000111; in_b = 28'h0000222; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 28'h0000333; in_b = 28'h0000111; in_sub = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data", obs, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_no_ghost", 32'(out_valid), 32'd0);
        end
        run_one("post_rst", 28'h0000100, 28'h0000023, 1'b0, pk(28'h0000123, 1'b0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
